flow_arbiter: RTL and testbench
===============================

Name: flow_arbiter

Overview:
- Round-robin arbiter that shares the single packet-command FIFO write port between N_FLOWS packet-manager instances.
- Takes each flow's request, acknowledge and command bundle (size, MACs, ethertype, payload), and issues a one-cycle grant to one flow at a time.
- Registers the granted flow's command onto the FIFO-side command bus, aligned with that flow's FIFO write-enable.
- Sits between the flow managers and the command FIFO/packet generator.

Parameters:
- N_FLOWS, 4, number of requesting flows (1..16).
- ACK_TIMEOUT, 15, max cycles spent waiting in HOLD for the granted flow's ack before forcing release (1..255).
- FLOW_WIDTH, derived, (N_FLOWS>1) ? clog2(N_FLOWS) : 1; localparam, not overridable.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-high reset.
- req  in  N_FLOWS  per-flow arb_request.
- ack  in  N_FLOWS  per-flow arb_ack.
- grant  out  N_FLOWS  one-hot per-flow arb_grant.
- fifo_wr_ready  in  1  command FIFO can accept a write.
- cmd_in  in  N_FLOWS*131  flattened per-flow {size[10:0], d_mac[47:0], s_mac[47:0], ethertype[15:0], payload[7:0]}; flow i at bits [i*131 +: 131].
- cmd_out  out  131  registered command of the last granted flow, same field order.
- cmd_valid  out  1  one-cycle pulse marking cmd_out as written to the FIFO.
- grant_id  out  FLOW_WIDTH  index of the current or last granted flow.
- busy  out  1  high when not in IDLE.
- timeout_err  out  1  sticky; set when an ack timeout occurs.

Behaviour:
- Reset (async, immediate): state=IDLE, rr_ptr=0, grant=0, cmd_out=0, cmd_valid=0, grant_id=0, busy=0, timeout_err=0, timeout counter=0.
- Each state below lasts one clock edge unless stated otherwise.
- IDLE:
  - If fifo_wr_ready and |req, pick winner w = first set req bit searching from rr_ptr upward, wrapping N_FLOWS-1 -> 0.
  - Next edge: grant=one-hot(w), grant_id=w, rr_ptr=(w+1) mod N_FLOWS, state=GRANT.
  - Otherwise stay in IDLE with grant=0.
- GRANT (exactly one cycle):
  - Next edge: grant=0, cmd_out=cmd_in[w], cmd_valid=fifo_wr_ready sampled this cycle, state=HOLD.
  - This matches the flow's registered fifo_wr_enable = grant && fifo_wr_ready.
- HOLD:
  - cmd_valid is low after its single pulse.
  - Counter increments each cycle.
  - If ack[grant_id]=1: state=IDLE, counter=0.
  - Else if counter == ACK_TIMEOUT-1: state=IDLE, counter=0, timeout_err=1.
- Latency and throughput:
  - req seen in IDLE at cycle t gives grant at t+1 and cmd_valid at t+2.
  - With ack tied high, minimum grant spacing is 3 cycles (IDLE, GRANT, HOLD).
- grant is one-hot or zero at all times and never asserted outside GRANT. grant_id holds its value until the next grant.
- req deasserted by the flow during GRANT is ignored; the grant completes.
- fifo_wr_ready low in IDLE blocks new grants. Low during GRANT: grant still completes, cmd_valid stays 0, rr_ptr is still advanced (the lost slot counts as served).
- Simultaneous requests: only the round-robin winner is served. Losers keep req high and are served in later rounds in pointer order.
- N_FLOWS=1: rr_ptr is constant 0, and the behaviour is otherwise identical.
- ack from non-granted flows is ignored.
- Reset asserted mid-GRANT or mid-HOLD: all outputs clear immediately, without waiting for a clock edge.
- busy = (state != IDLE), driven from registered state.

Decomposition:
- Shared package flow_arb_pkg:
  - CMD_W=131.
  - Field offsets: SIZE_LSB=120, DMAC_LSB=72, SMAC_LSB=24, ETYPE_LSB=8, PAYLOAD_LSB=0.
  - State encoding: IDLE=2'd0, GRANT=2'd1, HOLD=2'd2.
- Sub-module rr_select (combinational): inputs req and ptr; outputs winner index and any_valid. Implemented as a rotate-priority-unrotate.

Test Plan:
- Single flow: req=4'b0100, fifo_wr_ready=1, ack=1 -> grant=4'b0100 one cycle later; cmd_valid pulses the following cycle with cmd_out=flow 2 fields (size=64, payload=8'h1A); rr_ptr=3.
- Contention fairness: req=4'b1111 held, ack=1 -> grants in order 0,1,2,3,0, spaced 3 cycles apart, each grant exactly 1 cycle wide.
- Wrap-around: rr_ptr=3, req=4'b1001 -> flow 3 granted first, then flow 0; rr_ptr ends at 1.
- Backpressure: fifo_wr_ready=0 with req=4'b0010 -> grant stays 0 for 10 cycles. Raise ready -> grant=4'b0010 next cycle. Drop ready during GRANT -> cmd_valid stays 0.
- Ack timeout: ACK_TIMEOUT=15, ack=0 -> busy held 15 cycles in HOLD, then IDLE; timeout_err=1 stays high until reset.
- Async reset: assert rst mid-HOLD between clock edges -> grant, cmd_valid, busy, timeout_err read 0 before the next edge; first grant after reset goes to the lowest requesting index.

Source files
------------

// File: rtl/flow_arb_pkg.sv
// Shared types and constants for the flow arbiter: command layout, FSM states,
// and small helpers used by both RTL and bench.
package flow_arb_pkg;

  localparam int unsigned CMD_W       = 131;
  localparam int unsigned SIZE_LSB    = 120;
  localparam int unsigned DMAC_LSB    = 72;
  localparam int unsigned SMAC_LSB    = 24;
  localparam int unsigned ETYPE_LSB   = 8;
  localparam int unsigned PAYLOAD_LSB = 0;
  localparam int unsigned CNT_W       = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    HOLD  = 2'd2
  } state_e;

  typedef struct packed {
    logic [10:0] size;
    logic [47:0] d_mac;
    logic [47:0] s_mac;
    logic [15:0] ethertype;
    logic [7:0]  payload;
  } cmd_t;

  function automatic int unsigned flow_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // Builds a flat command word from its fields using the documented offsets
  function automatic logic [CMD_W-1:0] pack_cmd(input logic [10:0] size,
                                                input logic [47:0] d_mac,
                                                input logic [47:0] s_mac,
                                                input logic [15:0] ethertype,
                                                input logic [7:0]  payload);
    logic [CMD_W-1:0] v;
    v                       = '0;
    v[SIZE_LSB    +: 11]    = size;
    v[DMAC_LSB    +: 48]    = d_mac;
    v[SMAC_LSB    +: 48]    = s_mac;
    v[ETYPE_LSB   +: 16]    = ethertype;
    v[PAYLOAD_LSB +: 8]     = payload;
    return v;
  endfunction

endpackage

// File: rtl/flow_arb_if.sv
// Bundle between the flow managers and the arbiter; master is the arbiter side.
interface flow_arb_if
  import flow_arb_pkg::*;
#(
  parameter int unsigned N_FLOWS = 4
);
  localparam int unsigned FLOW_WIDTH = flow_width(N_FLOWS);

  logic [N_FLOWS-1:0]       req;
  logic [N_FLOWS-1:0]       ack;
  logic [N_FLOWS-1:0]       grant;
  logic                     fifo_wr_ready;
  logic [N_FLOWS*CMD_W-1:0] cmd_in;
  logic [CMD_W-1:0]         cmd_out;
  logic                     cmd_valid;
  logic [FLOW_WIDTH-1:0]    grant_id;
  logic                     busy;
  logic                     timeout_err;

  modport master (
    input  req, ack, fifo_wr_ready, cmd_in,
    output grant, cmd_out, cmd_valid, grant_id, busy, timeout_err
  );

  modport slave (
    output req, ack, fifo_wr_ready, cmd_in,
    input  grant, cmd_out, cmd_valid, grant_id, busy, timeout_err
  );

endinterface

// File: rtl/flow_arbiter_rr_select.sv
// Combinational round-robin pick: rotate requests so ptr is bit 0, take the
// lowest set bit, then rotate the index back.
module flow_arbiter_rr_select #(
  parameter int unsigned N = 4,
  parameter int unsigned W = 2
) (
  input  logic [N-1:0] req_i,
  input  logic [W-1:0] ptr_i,
  output logic [W-1:0] winner_o,
  output logic         any_valid_o
);

  logic [2*N-1:0] req_dbl;
  logic [N-1:0]   rot;
  logic [W-1:0]   rot_idx;
  logic [W:0]     sum;

  always_comb begin
    req_dbl = {req_i, req_i};
    rot     = N'(req_dbl >> ptr_i);
    rot_idx = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (rot[i]) rot_idx = W'(i);
    end
    sum = {1'b0, rot_idx} + {1'b0, ptr_i};
    if (sum >= (W+1)'(N)) sum = sum - (W+1)'(N);
    winner_o    = sum[W-1:0];
    any_valid_o = |req_i;
  end

endmodule

// File: rtl/flow_arbiter.sv
// Round-robin arbiter sharing the command-FIFO write port among N_FLOWS flow
// managers: one-cycle grant, then the winner's command is registered out.
module flow_arbiter
  import flow_arb_pkg::*;
#(
  parameter int unsigned N_FLOWS     = 4,
  parameter int unsigned ACK_TIMEOUT = 15
) (
  input  logic      clk,
  input  logic      rst,
  flow_arb_if.master bus
);

  localparam int unsigned FLOW_WIDTH = flow_width(N_FLOWS);

  state_e                 state_q, state_d;
  logic [FLOW_WIDTH-1:0]  rr_ptr_q, rr_ptr_d;
  logic [FLOW_WIDTH-1:0]  grant_id_q, grant_id_d;
  logic [N_FLOWS-1:0]     grant_q, grant_d;
  cmd_t                   cmd_out_q, cmd_out_d;
  logic                   cmd_valid_q, cmd_valid_d;
  logic                   timeout_err_q, timeout_err_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;

  logic [FLOW_WIDTH-1:0]  winner;
  logic                   any_valid;
  cmd_t                   cmd_sel;
  logic                   ack_sel;

  flow_arbiter_rr_select #(
    .N (N_FLOWS),
    .W (FLOW_WIDTH)
  ) u_rr_select (
    .req_i       (bus.req),
    .ptr_i       (rr_ptr_q),
    .winner_o    (winner),
    .any_valid_o (any_valid)
  );

  // Command and ack of the currently granted flow
  always_comb begin
    cmd_sel = '0;
    ack_sel = 1'b0;
    for (int i = 0; i < N_FLOWS; i++) begin
      if (grant_id_q == FLOW_WIDTH'(i)) begin
        cmd_sel = cmd_t'(bus.cmd_in[i*CMD_W +: CMD_W]);
        ack_sel = bus.ack[i];
      end
    end
  end

  always_comb begin
    state_d       = state_q;
    rr_ptr_d      = rr_ptr_q;
    grant_id_d    = grant_id_q;
    grant_d       = '0;
    cmd_out_d     = cmd_out_q;
    cmd_valid_d   = 1'b0;
    timeout_err_d = timeout_err_q;
    cnt_d         = cnt_q;

    case (state_q)
      IDLE: begin
        if (bus.fifo_wr_ready && any_valid) begin
          grant_d    = N_FLOWS'(1) << winner;
          grant_id_d = winner;
          rr_ptr_d   = (winner == FLOW_WIDTH'(N_FLOWS - 1)) ? '0
                                                             : winner + FLOW_WIDTH'(1);
          state_d    = GRANT;
        end
      end
      // Mirrors the flow's registered write-enable: grant && fifo_wr_ready
      GRANT: begin
        cmd_out_d   = cmd_sel;
        cmd_valid_d = bus.fifo_wr_ready;
        cnt_d       = '0;
        state_d     = HOLD;
      end
      HOLD: begin
        if (ack_sel) begin
          cnt_d   = '0;
          state_d = IDLE;
        end else if (cnt_q == CNT_W'(ACK_TIMEOUT - 1)) begin
          cnt_d         = '0;
          timeout_err_d = 1'b1;
          state_d       = IDLE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= IDLE;
      rr_ptr_q      <= '0;
      grant_id_q    <= '0;
      grant_q       <= '0;
      cmd_out_q     <= '0;
      cmd_valid_q   <= 1'b0;
      timeout_err_q <= 1'b0;
      cnt_q         <= '0;
    end else begin
      state_q       <= state_d;
      rr_ptr_q      <= rr_ptr_d;
      grant_id_q    <= grant_id_d;
      grant_q       <= grant_d;
      cmd_out_q     <= cmd_out_d;
      cmd_valid_q   <= cmd_valid_d;
      timeout_err_q <= timeout_err_d;
      cnt_q         <= cnt_d;
    end
  end

  assign bus.grant       = grant_q;
  assign bus.cmd_out     = cmd_out_q;
  assign bus.cmd_valid   = cmd_valid_q;
  assign bus.grant_id    = grant_id_q;
  assign bus.busy        = (state_q != IDLE);
  assign bus.timeout_err = timeout_err_q;

endmodule

// File: tb/tb_flow_arbiter.sv
// Directed bench for flow_arbiter with a grant/command scoreboard.
module tb_flow_arbiter;
  import flow_arb_pkg::*;

  localparam int unsigned N      = 4;
  localparam int unsigned ACK_TO = 15;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  flow_arb_if #(.N_FLOWS(N)) bus ();

  flow_arbiter #(.N_FLOWS(N), .ACK_TIMEOUT(ACK_TO)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int tests = 0;
  int fails = 0;
  int cyc   = 0;
  always @(posedge clk) cyc++;

  int               exp_gnt_q[$];
  logic [CMD_W-1:0] exp_cmd_q[$];
  logic [N-1:0]     prev_grant = '0;
  logic [N-1:0]     mon_oh;
  int               mon_e;

  function automatic logic [CMD_W-1:0] flow_cmd(input int i);
    return pack_cmd(11'(16 * (i + 2)), 48'h02AA_0000_0000 + 48'(i),
                    48'h0A00_0000_0000 + 48'(i), 16'h0800 + 16'(i), 8'h18 + 8'(i));
  endfunction

  task automatic chk(input string tag, input logic [CMD_W-1:0] got, input logic [CMD_W-1:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic expect_txn(input int i, input bit with_cmd);
    exp_gnt_q.push_back(i);
    if (with_cmd) exp_cmd_q.push_back(flow_cmd(i));
  endtask

  task automatic wait_grant(input string tag, output int c);
    int n;
    n = 0;
    c = -1;
    while (n < 30) begin
      @(negedge clk);
      if (bus.grant !== '0) begin
        c = cyc;
        break;
      end
      n++;
    end
    if (c < 0) begin
      tests++;
      fails++;
      $error("FAIL %s: observed no grant within 30 cycles, expected a grant", tag);
    end
  endtask

  // Scoreboard: every grant and every cmd_valid pulse must match the next expectation
  always @(negedge clk) begin
    if (!rst) begin
      if (bus.grant !== '0) begin
        chk("gnt_width", CMD_W'(prev_grant), '0);
        if (exp_gnt_q.size() == 0) begin
          chk("gnt_unexpected", CMD_W'(bus.grant), '0);
        end else begin
          mon_e  = exp_gnt_q.pop_front();
          mon_oh = N'(1) << mon_e;
          chk("gnt_onehot", CMD_W'(bus.grant), CMD_W'(mon_oh));
          chk("gnt_id", CMD_W'(bus.grant_id), CMD_W'(mon_e));
        end
      end
      if (bus.cmd_valid === 1'b1) begin
        if (exp_cmd_q.size() == 0) chk("cmd_unexpected", CMD_W'(bus.cmd_valid), '0);
        else chk("cmd_out", bus.cmd_out, exp_cmd_q.pop_front());
      end
    end
    prev_grant = bus.grant;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: observed no finish, expected finish before 100000ns");
    $fatal(1);
  end

  initial begin
    int c, last, n;
    rst               = 1'b1;
    bus.req           = '0;
    bus.ack           = '0;
    bus.fifo_wr_ready = 1'b0;
    for (int i = 0; i < N; i++) bus.cmd_in[i*CMD_W +: CMD_W] = flow_cmd(i);

    repeat (3) @(negedge clk);
    chk("rst_grant", CMD_W'(bus.grant), '0);
    chk("rst_cmd_out", bus.cmd_out, '0);
    chk("rst_cmd_valid", CMD_W'(bus.cmd_valid), '0);
    chk("rst_grant_id", CMD_W'(bus.grant_id), '0);
    chk("rst_busy", CMD_W'(bus.busy), '0);
    chk("rst_timeout_err", CMD_W'(bus.timeout_err), '0);
    rst               = 1'b0;
    bus.fifo_wr_ready = 1'b1;
    bus.ack           = '1;

    // Contention: all flows request, served 0,1,2,3,0 three cycles apart
    @(posedge clk); #1;
    for (int k = 0; k < 5; k++) expect_txn(k % 4, 1'b1);
    bus.req = 4'b1111;
    last = 0;
    for (int k = 0; k < 5; k++) begin
      wait_grant("cont_grant", c);
      if (k == 4) bus.req = '0;
      if (k > 0) chk("cont_spacing", CMD_W'(c - last), CMD_W'(3));
      last = c;
    end
    repeat (3) @(negedge clk);
    chk("cont_idle", CMD_W'(bus.busy), '0);

    // Single flow 2: grant one cycle after req, cmd_valid one cycle later
    @(posedge clk); #1;
    expect_txn(2, 1'b1);
    bus.req = 4'b0100;
    @(negedge clk);
    chk("lat_gnt_pre", CMD_W'(bus.grant), '0);
    @(negedge clk);
    chk("lat_gnt", CMD_W'(bus.grant), CMD_W'(4'b0100));
    bus.req = '0;
    @(negedge clk);
    chk("lat_cmd_valid", CMD_W'(bus.cmd_valid), CMD_W'(1));
    chk("lat_size", CMD_W'(bus.cmd_out[SIZE_LSB +: 11]), CMD_W'(64));
    chk("lat_payload", CMD_W'(bus.cmd_out[PAYLOAD_LSB +: 8]), CMD_W'(8'h1A));
    @(negedge clk);
    chk("lat_cmd_pulse", CMD_W'(bus.cmd_valid), '0);
    chk("lat_grant_id_hold", CMD_W'(bus.grant_id), CMD_W'(2));
    repeat (2) @(negedge clk);

    // Wrap-around: pointer at 3, flows 3 then 0
    expect_txn(3, 1'b1);
    expect_txn(0, 1'b1);
    bus.req = 4'b1001;
    wait_grant("wrap_first", c);
    chk("wrap_first_id", CMD_W'(bus.grant_id), CMD_W'(3));
    wait_grant("wrap_second", last);
    bus.req = '0;
    chk("wrap_spacing", CMD_W'(last - c), CMD_W'(3));
    repeat (3) @(negedge clk);

    // Backpressure: no grant while not ready; lost slot when ready drops in GRANT
    bus.fifo_wr_ready = 1'b0;
    expect_txn(1, 1'b0);
    bus.req = 4'b0010;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      chk("bp_no_grant", CMD_W'(bus.grant), '0);
    end
    bus.fifo_wr_ready = 1'b1;
    @(negedge clk);
    chk("bp_grant", CMD_W'(bus.grant), CMD_W'(4'b0010));
    bus.fifo_wr_ready = 1'b0;
    bus.req           = '0;
    @(negedge clk);
    chk("bp_no_cmd_valid", CMD_W'(bus.cmd_valid), '0);
    chk("bp_busy", CMD_W'(bus.busy), CMD_W'(1));
    bus.fifo_wr_ready = 1'b1;
    repeat (3) @(negedge clk);

    // The lost slot still advanced the pointer: flow 2 before flow 1
    expect_txn(2, 1'b1);
    expect_txn(1, 1'b1);
    bus.req = 4'b0110;
    wait_grant("lost_first", c);
    wait_grant("lost_second", last);
    bus.req = '0;
    repeat (3) @(negedge clk);

    // Ack timeout; acks from non-granted flows must not release HOLD
    bus.ack = 4'b1110;
    expect_txn(0, 1'b1);
    bus.req = 4'b0001;
    wait_grant("to_grant", c);
    bus.req = '0;
    chk("to_err_before", CMD_W'(bus.timeout_err), '0);
    n = 0;
    while (n < 40) begin
      @(negedge clk);
      if (bus.busy !== 1'b1) break;
      n++;
    end
    chk("to_hold_cycles", CMD_W'(n), CMD_W'(ACK_TO));
    chk("to_err_set", CMD_W'(bus.timeout_err), CMD_W'(1));
    bus.ack = '1;
    expect_txn(3, 1'b1);
    bus.req = 4'b1000;
    wait_grant("to_after", c);
    bus.req = '0;
    repeat (4) @(negedge clk);
    chk("to_err_sticky", CMD_W'(bus.timeout_err), CMD_W'(1));

    // Async reset between edges while in HOLD
    bus.ack = '0;
    expect_txn(1, 1'b1);
    bus.req = 4'b0010;
    wait_grant("ar_grant", c);
    bus.req = '0;
    @(negedge clk);
    #1 rst = 1'b1;
    #1;
    chk("ar_grant", CMD_W'(bus.grant), '0);
    chk("ar_cmd_valid", CMD_W'(bus.cmd_valid), '0);
    chk("ar_busy", CMD_W'(bus.busy), '0);
    chk("ar_timeout_err", CMD_W'(bus.timeout_err), '0);
    chk("ar_cmd_out", bus.cmd_out, '0);
    exp_gnt_q.delete();
    exp_cmd_q.delete();
    @(negedge clk);
    rst     = 1'b0;
    bus.ack = '1;
    expect_txn(1, 1'b1);
    bus.req = 4'b1010;
    wait_grant("ar_first", c);
    bus.req = '0;
    chk("ar_first_id", CMD_W'(bus.grant_id), CMD_W'(1));
    repeat (4) @(negedge clk);

    chk("sb_drain", CMD_W'(exp_gnt_q.size() + exp_cmd_q.size()), '0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
